// File: rtl/ext_unit_issue_arbiter.sv
// ext_unit_issue_arbiter: shares one execution unit between NUM_REQ requesters.
// Round-robin grant, one op in flight, aq/rl ownership lock and a response
// watchdog. Define ARB_PERF_CNT_EN to build the perf_ops/perf_busy counters;
// without it both outputs are tied to zero.
module ext_unit_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*76-1:0] req_op,
  output logic                  eu_valid_in,
  output logic [31:0]           eu_rs1,
  output logic [31:0]           eu_rs2,
  output logic [6:0]            eu_funct7,
  output logic [2:0]            eu_funct3,
  output logic                  eu_aq,
  output logic                  eu_rl,
  input  logic [31:0]           eu_result,
  input  logic                  eu_valid_out,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  lock_active,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_busy
);
  localparam int OP_W  = 76;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner_p0;
  logic [IDX_W-1:0]   lock_owner;
  logic               lock_q;
  logic [WD_W-1:0]    wd;
  logic [OP_W-1:0]    op_p0;
  logic [31:0]        res_p1;
  logic               err_p1;
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W:0]     pick;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [OP_W-1:0]    grant_op;
  logic               wd_expired;

  // First set bit of elig at or after ptr, wrapping; returns {found, index}
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  // Successor index modulo NUM_REQ
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Eligible set: all pending requesters, or only the lock owner while locked
  always_comb begin
    elig = req_valid;
    if (lock_q) elig = req_valid & (NUM_REQ'(1) << lock_owner);
    pick = rr_pick(elig, rr_ptr);
  end

  assign grant_found = pick[IDX_W];
  assign grant_idx   = pick[IDX_W-1:0];
  assign grant_op    = req_op[OP_W*int'(grant_idx) +: OP_W];
  // The first WAIT cycle is already one cycle past issue, hence TIMEOUT-2
  assign wd_expired  = (wd == WD_W'(TIMEOUT - 2));

  // Next-state and strobe outputs
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    eu_valid_in = 1'b0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = !rst;
          state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eu_valid_in = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (eu_valid_out || wd_expired) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner_p0] = 1'b1;
        rsp_data            = res_p1;
        rsp_err             = err_p1;
        state_nxt           = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // p0: capture winner and its op at accept; held on eu_* until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_p0 <= '0;
      op_p0    <= '0;
    end else if (state == S_IDLE && grant_found) begin
      owner_p0 <= grant_idx;
      op_p0    <= grant_op;
    end
  end

  // Response watchdog: zeroed on issue, counts while waiting
  always_ff @(posedge clk) begin
    if (rst)                  wd <= '0;
    else if (state == S_ISSUE) wd <= '0;
    else if (state == S_WAIT)  wd <= wd + 1'b1;
  end

  // p1: result capture; a result arriving on the expiry cycle still wins
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= '0;
      err_p1 <= 1'b0;
    end else if (state == S_WAIT) begin
      if (eu_valid_out) begin
        res_p1 <= eu_result;
        err_p1 <= 1'b0;
      end else if (wd_expired) begin
        res_p1 <= '0;
        err_p1 <= 1'b1;
      end
    end
  end

  // Round-robin pointer and ownership lock, both settled on the response cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_owner <= '0;
    end else if (state == S_RESP) begin
      rr_ptr <= wrap_inc(owner_p0);
      if (err_p1) begin
        lock_q <= 1'b0;
      end else if (op_p0[1] && !op_p0[0]) begin
        lock_q     <= 1'b1;
        lock_owner <= owner_p0;
      end else if (op_p0[0] && !op_p0[1] && lock_q && lock_owner == owner_p0) begin
        lock_q <= 1'b0;
      end
    end
  end

  assign eu_funct7   = op_p0[75:69];
  assign eu_funct3   = op_p0[68:66];
  assign eu_rs1      = op_p0[65:34];
  assign eu_rs2      = op_p0[33:2];
  assign eu_aq       = op_p0[1];
  assign eu_rl       = op_p0[0];
  assign lock_active = lock_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] ops_cnt;
  logic [31:0] busy_cnt;

  // Completed-op and busy-cycle counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt  <= '0;
      busy_cnt <= '0;
    end else begin
      if (state == S_RESP) ops_cnt  <= ops_cnt + 32'd1;
      if (state != S_IDLE) busy_cnt <= busy_cnt + 32'd1;
    end
  end

  assign perf_ops  = ops_cnt;
  assign perf_busy = busy_cnt;
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_ext_unit_issue_arbiter.sv
// Self-checking bench for ext_unit_issue_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model (age of the in-flight op, response cycle, lock owner).
`timescale 1ns/1ps
module tb_ext_unit_issue_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*76-1:0] req_op;
  logic                  eu_valid_in;
  logic [31:0]           eu_rs1, eu_rs2;
  logic [6:0]            eu_funct7;
  logic [2:0]            eu_funct3;
  logic                  eu_aq, eu_rl;
  logic [31:0]           eu_result;
  logic                  eu_valid_out;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  lock_active;
  logic [31:0]           perf_ops, perf_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ext_unit_issue_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .eu_valid_in(eu_valid_in), .eu_rs1(eu_rs1), .eu_rs2(eu_rs2),
    .eu_funct7(eu_funct7), .eu_funct3(eu_funct3), .eu_aq(eu_aq), .eu_rl(eu_rl),
    .eu_result(eu_result), .eu_valid_out(eu_valid_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .lock_active(lock_active),
    .perf_ops(perf_ops), .perf_busy(perf_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [75:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic aq, input logic rl);
    return {f7, f3, a, b, aq, rl};
  endfunction

  function automatic int oh2i(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- EU model ----------------
  int          eu_lat   = 1;   // >0 fixed latency, 0 random
  bit          eu_stray = 1'b0;
  int          eu_rem   = 0;
  logic [31:0] eu_res_q = '0;

  always @(negedge clk) begin
    if (eu_valid_in === 1'b1 && rst === 1'b0) begin
      if (eu_lat > 0) eu_rem = eu_lat;
      else eu_rem = ($urandom_range(0, 31) == 0) ? 70 : int'($urandom_range(1, 8));
      eu_res_q = eu_rs1 ^ eu_rs2;
    end
  end

  always @(posedge clk) begin
    #1;
    eu_valid_out = 1'b0;
    if (eu_rem > 0) begin
      eu_rem--;
      if (eu_rem == 0) begin
        eu_valid_out = 1'b1;
        eu_result    = eu_res_q;
      end
    end else if (eu_stray && $urandom_range(0, 15) == 0) begin
      eu_valid_out = 1'b1;
      eu_result    = $urandom;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int                 m_busy, m_own, m_age, m_resp_at, m_rr, m_lock, win;
  logic [75:0]        m_op;
  logic [31:0]        m_data, m_ops, m_busyc;
  logic               m_err;
  logic [NUM_REQ-1:0] e_ready, e_rsp;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      m_busy = 0; m_own = 0; m_age = 0; m_resp_at = -1; m_rr = 0; m_lock = -1;
      m_op = '0; m_data = '0; m_err = 1'b0; m_ops = '0; m_busyc = '0;
    end else begin
      win = -1;
      if (m_busy == 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (m_rr + k) % NUM_REQ;
          if (win < 0 && req_valid[idx] && (m_lock < 0 || m_lock == idx)) win = idx;
        end
      end
      e_ready = '0;
      if (win >= 0) e_ready[win] = 1'b1;
      e_rsp = '0;
      if (m_busy != 0 && m_age == m_resp_at) e_rsp[m_own] = 1'b1;

      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("eu_valid_in", 32'(eu_valid_in), 32'(m_busy != 0 && m_age == 1));
      chk("eu_rs1", eu_rs1, m_op[65:34]);
      chk("eu_rs2", eu_rs2, m_op[33:2]);
      chk("eu_ctl", 32'({eu_funct7, eu_funct3, eu_aq, eu_rl}), 32'({m_op[75:66], m_op[1:0]}));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_data", rsp_data, (e_rsp != 0) ? m_data : 32'd0);
      chk("rsp_err", 32'(rsp_err), 32'(e_rsp != 0 && m_err));
      chk("lock_active", 32'(lock_active), 32'(m_lock >= 0));
`ifdef ARB_PERF_CNT_EN
      chk("perf_ops", perf_ops, m_ops);
      chk("perf_busy", perf_busy, m_busyc);
`else
      chk("perf_off", perf_ops | perf_busy, 32'd0);
`endif

      if (m_busy != 0) begin
        m_busyc++;
        if (m_age == m_resp_at) begin
          if (m_err) m_lock = -1;
          else if (m_op[1] && !m_op[0]) m_lock = m_own;
          else if (m_op[0] && !m_op[1] && m_lock == m_own) m_lock = -1;
          m_rr   = (m_own + 1) % NUM_REQ;
          m_busy = 0;
          m_ops++;
        end else begin
          if (m_resp_at < 0 && m_age >= 2) begin
            if (eu_valid_out) begin
              m_resp_at = m_age + 1; m_data = eu_result; m_err = 1'b0;
            end else if (m_age == TIMEOUT) begin
              m_resp_at = m_age + 1; m_data = '0; m_err = 1'b1;
            end
          end
          m_age++;
        end
      end else if (win >= 0) begin
        m_busy = 1; m_own = win; m_age = 1; m_resp_at = -1;
        m_op = req_op[76*win +: 76];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    eu_rem = 0; eu_stray = 1'b0; req_valid = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [75:0] op);
    req_op[76*i +: 76] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int bound, output int idx);
    idx = -1;
    for (int c = 0; c < bound && idx < 0; c++) begin
      @(negedge clk);
      if (req_ready != 0) idx = oh2i(req_ready);
      step();
    end
  endtask

  function automatic logic [75:0] rand_op();
    return mk(7'($urandom), 3'($urandom), $urandom, $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w, cnt, vin_cnt, cyc;
    int g[$];
    int gc[$];
    int exp_order[5];
    logic [NUM_REQ-1:0] acc;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_op = '0; eu_valid_out = 1'b0; eu_result = '0;
    #1;

    // --- single op from req0, EU latency 3 ---
    do_reset();
    eu_lat = 3;
    set_req(0, mk(7'h4A, 3'd0, 32'd10, 32'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t1_vin", 32'(eu_valid_in), 32'h1);
    chk("t1_f7", 32'(eu_funct7), 32'h4A);
    repeat (4) step();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'hA);
    chk("t1_rsp_err", 32'(rsp_err), 32'h0);
    step();

    // --- round robin, all requesters asserted, EU latency 1 ---
    do_reset();
    eu_lat = 1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, mk(7'(i), 3'd1, 32'(i * 3), 32'd7, 1'b0, 1'b0));
    cyc = 0; vin_cnt = 0;
    while (g.size() < 5 && cyc < 60) begin
      @(negedge clk);
      if (eu_valid_in) vin_cnt++;
      if (req_ready != 0) begin g.push_back(oh2i(req_ready)); gc.push_back(cyc); end
      step(); cyc++;
    end
    chk("t2_grants", 32'(g.size()), 32'd5);
    for (int k = 0; k < g.size() && k < 5; k++) chk("t2_order", 32'(g[k]), 32'(exp_order[k]));
    for (int k = 1; k < gc.size(); k++) chk("t2_spacing", 32'(gc[k] - gc[k-1]), 32'd4);
    chk("t2_vin_count", 32'(vin_cnt), 32'd4);
    req_valid = '0;
    repeat (6) step();

    // --- lock: req1 aq, then req0/req1 compete, release with rl ---
    do_reset();
    eu_lat = 2;
    set_req(1, mk(7'h11, 3'd2, 32'd5, 32'd6, 1'b1, 1'b0));
    wait_grant(10, w); chk("t3_g_aq", 32'(w), 32'd1);
    req_valid[1] = 1'b0;
    repeat (6) step();
    @(negedge clk); chk("t3_lock_set", 32'(lock_active), 32'd1);
    step();
    set_req(0, mk(7'h20, 3'd0, 32'd1, 32'd2, 1'b0, 1'b0));
    set_req(1, mk(7'h21, 3'd0, 32'd3, 32'd4, 1'b0, 1'b0));
    wait_grant(10, w); chk("t3_g_locked1", 32'(w), 32'd1);
    set_req(1, mk(7'h22, 3'd0, 32'd8, 32'd9, 1'b0, 1'b1));
    wait_grant(10, w); chk("t3_g_locked2", 32'(w), 32'd1);
    req_valid[1] = 1'b0;
    set_req(2, mk(7'h23, 3'd0, 32'd4, 32'd4, 1'b0, 1'b0));
    wait_grant(20, w); chk("t3_g_after_rl", 32'(w), 32'd2);
    @(negedge clk); chk("t3_lock_clear", 32'(lock_active), 32'd0);
    step();
    req_valid = '0;
    repeat (8) step();

    // --- watchdog: EU never answers in time ---
    do_reset();
    eu_lat = 2;
    set_req(0, mk(7'h30, 3'd3, 32'd1, 32'd1, 1'b1, 1'b0));
    wait_grant(10, w); req_valid = '0;
    repeat (6) step();
    eu_lat = 80;
    set_req(0, mk(7'h31, 3'd3, 32'd2, 32'd9, 1'b0, 1'b0));
    wait_grant(10, w); chk("t4_grant", 32'(w), 32'd0);
    req_valid = '0;
    repeat (63) step();
    @(negedge clk); chk("t4_not_early", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_err", 32'(rsp_err), 32'h1);
    chk("t4_rsp_data", rsp_data, 32'd0);
    step();
    @(negedge clk); chk("t4_lock_cleared", 32'(lock_active), 32'd0);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin step(); @(negedge clk); if (rsp_valid != 0) cnt++; end
    chk("t4_stale_ignored", 32'(cnt), 32'd0);
    step();

    // --- reset during WAIT ---
    do_reset();
    eu_lat = 1;
    set_req(2, mk(7'h40, 3'd4, 32'd3, 32'd3, 1'b0, 1'b0));
    wait_grant(10, w); req_valid = '0;
    repeat (5) step();
    eu_lat = 5;
    set_req(2, mk(7'h41, 3'd5, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0));
    wait_grant(10, w); chk("t5_grant", 32'(w), 32'd2);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_zero", 32'({req_ready, eu_valid_in, rsp_valid, rsp_err, lock_active,
                        eu_funct7, eu_funct3, eu_aq, eu_rl} != 0), 32'd0);
    chk("t5_zero_data", eu_rs1 | eu_rs2 | rsp_data | perf_ops | perf_busy, 32'd0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin step(); @(negedge clk); if (rsp_valid != 0) cnt++; end
    chk("t5_no_rsp", 32'(cnt), 32'd0);
    step();
    set_req(1, mk(7'h42, 3'd0, 32'd1, 32'd0, 1'b0, 1'b0));
    set_req(3, mk(7'h43, 3'd0, 32'd2, 32'd0, 1'b0, 1'b0));
    wait_grant(10, w); chk("t5_rr_reset", 32'(w), 32'd1);
    req_valid = '0;
    repeat (8) step();

    // --- perf counters, three ops at EU latency 2 ---
    do_reset();
    eu_lat = 2;
    set_req(0, mk(7'h50, 3'd0, 32'd7, 32'd1, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      wait_grant(12, w); chk("t6_grant", 32'(w), 32'd0);
    end
    req_valid = '0;
    repeat (6) step();
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_ops", perf_ops, 32'd3);
`else
    chk("t6_perf_ops_off", perf_ops, 32'd0);
    chk("t6_perf_busy_off", perf_busy, 32'd0);
`endif
    step();

    // --- randomized traffic ---
    do_reset();
    eu_lat = 0; eu_stray = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_op());
      end
    end
    rst = 1'b0; req_valid = '0; eu_stray = 1'b0;
    repeat (100) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
